// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, func3
// values, FSM state encodings and datapath mux selects.
package riscv_pkg;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Branch func3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // I-type shift func3 and the func7 values they accept
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_MEM_ADR   = 5'd2,
    S_MEM_READ  = 5'd3,
    S_MEM_WB    = 5'd4,
    S_MEM_WRITE = 5'd5,
    S_EXEC_R    = 5'd6,
    S_EXEC_I    = 5'd7,
    S_LUI       = 5'd8,
    S_AUIPC     = 5'd9,
    S_ALU_WB    = 5'd10,
    S_BRANCH    = 5'd11,
    S_JAL       = 5'd12,
    S_JALR      = 5'd13,
    S_LINK_WB   = 5'd14,
    S_TRAP      = 5'd15,
    S_HALT      = 5'd31
  } state_e;

  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JALR = 2'b10, PC_TRAP = 2'b11} pc_src_e;
  typedef enum logic [1:0] {A_PC = 2'b00, A_RS1 = 2'b01, A_OLD_PC = 2'b10, A_ZERO = 2'b11} alu_src_a_e;
  typedef enum logic [1:0] {B_RS2 = 2'b00, B_FOUR = 2'b01, B_IMM = 2'b10} alu_src_b_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_RFN = 2'b10, ALU_IFN = 2'b11} alu_op_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10} mem_to_reg_e;

  // Shift-immediate forms constrain func7; every other I-ALU func3 is legal.
  function automatic logic ialu_legal(input logic [2:0] f3, input logic [6:0] f7);
    logic ok;
    ok = 1'b1;
    if (f3 == F3_SLL) ok = (f7 == F7_ZERO);
    if (f3 == F3_SR)  ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
    return ok;
  endfunction

  // func3 010 and 011 have no branch meaning.
  function automatic logic branch_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/riscv_branch_eval.sv
// Resolves the branch condition from func3 and the ALU compare flags.
module riscv_branch_eval
  import riscv_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       taken
);

  // Pick the flag (or its inverse) the branch type tests.
  always_comb begin
    case (func3)
      F3_BEQ:  taken = alu_zero;
      F3_BNE:  taken = !alu_zero;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      F3_BLTU: taken = alu_ltu;
      F3_BGEU: taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V control FSM: drives every datapath select and strobe,
// waits on the memory handshake under a watchdog, and traps or halts on
// illegal instructions.
module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE   = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b0,
  parameter int unsigned CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       mem_ready,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic       mem_timeout,
  output logic       halted,
  output logic [4:0] state_o
);

  localparam bit WD_ON = MEM_HANDSHAKE && (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state;
  state_e           state_next;
  state_e           cur;
  logic [CNT_W-1:0] wd_cnt;
  logic             to_cause;
  logic             taken;
  logic             mem_done;
  logic             wait_state;
  logic             wd_expire;

  riscv_branch_eval u_branch_eval (
    .func3    (func3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .alu_ltu  (alu_ltu),
    .taken    (taken)
  );

  // Without the handshake every access is treated as finishing in one cycle.
  assign mem_done   = mem_ready | !MEM_HANDSHAKE;
  assign wait_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign wd_expire  = WD_ON && wait_state && !mem_done && (wd_cnt == WD_LAST);

  // Outputs show the FETCH decode while reset is held, whatever the register holds.
  assign cur     = rst ? S_FETCH : state;
  assign state_o = cur;

  // State register and trap-cause flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset is synchronous, tested inside the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      to_cause <= 1'b0;
    end else begin
      state    <= state_next;
      to_cause <= wd_expire;
    end
  end

  // Watchdog: restarts on any state change, counts idle cycles in wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state_next != state) begin
      wd_cnt <= '0;
    end else if (WD_ON && wait_state && !mem_done) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Next-state logic; a watchdog expiry overrides the normal transition.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:     state_next = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = ialu_legal(func3, func7) ? S_EXEC_I : S_TRAP;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          OP_BRANCH:         state_next = branch_legal(func3) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM_ADR:   state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next = mem_done ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = mem_done ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JAL, S_JALR: state_next = S_LINK_WB;
      S_LINK_WB:   state_next = S_FETCH;
      S_TRAP:      state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_FETCH;
    endcase
    if (wd_expire) state_next = S_TRAP;
  end

  // Output decode (Moore, plus the ready- and branch-gated PC/IR strobes).
  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    iord        = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_ALU;
    alu_src_a   = A_PC;
    alu_src_b   = B_RS2;
    alu_op      = ALU_ADD;
    mem_to_reg  = WB_ALU;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    halted      = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = B_FOUR;
        ir_write  = mem_done;
        pc_write  = mem_done;
      end
      S_DECODE: begin
        alu_src_a = A_OLD_PC;
        alu_src_b = B_IMM;
      end
      S_MEM_ADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = WB_MDR;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_RFN;
      end
      S_EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_IFN;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
      end
      S_AUIPC: begin
        alu_src_a = A_OLD_PC;
        alu_src_b = B_IMM;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = taken;
      end
      S_JAL: begin
        pc_src   = PC_ALUOUT;
        pc_write = 1'b1;
      end
      S_JALR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        pc_src    = PC_JALR;
        pc_write  = 1'b1;
      end
      S_LINK_WB: begin
        mem_to_reg = WB_PC;
        reg_write  = 1'b1;
      end
      S_TRAP: begin
        illegal     = !to_cause;
        mem_timeout = to_cause;
        if (!HALT_ON_ILLEGAL) begin
          pc_src   = PC_TRAP;
          pc_write = 1'b1;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
